// File: rtl/hdmi_text_render_if.sv
// Memory-side bus of the text renderer: VRAM cell fetch and glyph ROM row fetch.
// The renderer is the master; the VRAM/ROM wrapper is the slave.
interface hdmi_text_render_if #(
    parameter int unsigned COLS    = 100,
    parameter int unsigned ROWS    = 30,
    parameter int unsigned GLYPH_W = 10,
    parameter int unsigned GLYPH_H = 20
);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned GY_W  = $clog2(GLYPH_H);

    logic               vram_ce;
    logic [ROW_W-1:0]   vram_row;
    logic [COL_W-1:0]   vram_col;
    logic [15:0]        vram_data;
    logic               glyph_ce;
    logic [7:0]         glyph_char;
    logic [GY_W-1:0]    glyph_row;
    logic [GLYPH_W-1:0] glyph_bits;

    modport master (
        output vram_ce, vram_row, vram_col, glyph_ce, glyph_char, glyph_row,
        input  vram_data, glyph_bits
    );

    modport slave (
        input  vram_ce, vram_row, vram_col, glyph_ce, glyph_char, glyph_row,
        output vram_data, glyph_bits
    );
endinterface

// File: rtl/hdmi_text_render.sv
// Text-mode renderer: timing strobes -> cell coordinates -> VRAM word -> glyph row -> 24-bit
// pixels with per-cell 16-colour attributes and a blinking inverse cursor. Fixed 4-cycle delay.
module hdmi_text_render #(
    parameter int unsigned COLS         = 100,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned GLYPH_W      = 10,
    parameter int unsigned GLYPH_H      = 20,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_active,
    input  logic                    in_h_sync,
    input  logic                    in_v_sync,
    input  logic                    in_h_start,
    input  logic                    in_v_start,
    input  logic [$clog2(ROWS)-1:0] top_row,
    input  logic                    cursor_en,
    input  logic [$clog2(ROWS)-1:0] cursor_row,
    input  logic [$clog2(COLS)-1:0] cursor_col,
    hdmi_text_render_if.master      mem,
    output logic                    out_active,
    output logic                    out_h_sync,
    output logic                    out_v_sync,
    output logic [23:0]             out_rgb
);
    localparam int unsigned COL_W = $clog2(COLS);
    localparam int unsigned ROW_W = $clog2(ROWS);
    localparam int unsigned GX_W  = $clog2(GLYPH_W);
    localparam int unsigned GY_W  = $clog2(GLYPH_H);
    localparam int unsigned FC_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [GX_W-1:0]  GX_LAST  = GX_W'(GLYPH_W - 1);
    localparam logic [GY_W-1:0]  GY_LAST  = GY_W'(GLYPH_H - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_FRAMES - 1);

    // Index {i,r,g,b}: set components are AA, or FF when intense; clear ones are 00, or 55.
    function automatic logic [23:0] palette(input logic [3:0] idx);
        logic [7:0] on, off;
        on  = idx[3] ? 8'hFF : 8'hAA;
        off = idx[3] ? 8'h55 : 8'h00;
        return {idx[2] ? on : off, idx[1] ? on : off, idx[0] ? on : off};
    endfunction

    // Stage 1: position counters and blink state
    logic [COL_W-1:0] col;
    logic [GX_W-1:0]  gx;
    logic [ROW_W-1:0] row;
    logic [GY_W-1:0]  gy;
    logic             s1_active, s1_hs, s1_vs;
    logic [FC_W-1:0]  frame_cnt;
    logic             frame_seen;
    logic             phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col        <= '0;
            gx         <= '0;
            row        <= '0;
            gy         <= '0;
            s1_active  <= 1'b0;
            s1_hs      <= 1'b0;
            s1_vs      <= 1'b0;
            frame_cnt  <= '0;
            frame_seen <= 1'b0;
            phase      <= 1'b1;
        end else begin
            s1_active <= in_active;
            s1_hs     <= in_h_sync;
            s1_vs     <= in_v_sync;

            if (in_v_start) begin
                row <= top_row;
                gy  <= '0;
            end else if (in_h_start) begin
                if (gy == GY_LAST) begin
                    gy  <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
                end else begin
                    gy <= gy + GY_W'(1);
                end
            end

            if (in_h_start) begin
                col <= '0;
                gx  <= '0;
            end else if (in_active) begin
                if (gx == GX_LAST) begin
                    gx <= '0;
                    if (col != COL_LAST) col <= col + COL_W'(1);
                end else begin
                    gx <= gx + GX_W'(1);
                end
            end

            // The first v_start after reset opens frame 0 rather than counting a finished frame,
            // so the cursor stays visible for exactly BLINK_FRAMES frames per half-period.
            if (in_v_start) begin
                if (!frame_seen) begin
                    frame_seen <= 1'b1;
                end else if (frame_cnt == FC_LAST) begin
                    frame_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    frame_cnt <= frame_cnt + FC_W'(1);
                end
            end
        end
    end

    logic cell_start;
    logic cursor_hit;

    assign cell_start = s1_active && (gx == '0);
    assign cursor_hit = cursor_en && phase && (row == cursor_row) && (col == cursor_col);

    assign mem.vram_ce  = cell_start;
    assign mem.vram_row = row;
    assign mem.vram_col = col;

    // Stages 2 and 3: VRAM word arrives, glyph fetch issued, attribute carried alongside
    logic            s2_cell, s2_hit, s2_active, s2_hs, s2_vs;
    logic [GY_W-1:0] s2_gy;
    logic            s3_cell, s3_hit, s3_active, s3_hs, s3_vs;
    logic [7:0]      s3_attr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_cell   <= 1'b0;
            s2_hit    <= 1'b0;
            s2_active <= 1'b0;
            s2_hs     <= 1'b0;
            s2_vs     <= 1'b0;
            s2_gy     <= '0;
            s3_cell   <= 1'b0;
            s3_hit    <= 1'b0;
            s3_active <= 1'b0;
            s3_hs     <= 1'b0;
            s3_vs     <= 1'b0;
            s3_attr   <= '0;
        end else begin
            s2_cell   <= cell_start;
            s2_active <= s1_active;
            s2_hs     <= s1_hs;
            s2_vs     <= s1_vs;
            s2_gy     <= gy;
            if (cell_start) s2_hit <= cursor_hit;

            s3_cell   <= s2_cell;
            s3_active <= s2_active;
            s3_hs     <= s2_hs;
            s3_vs     <= s2_vs;
            if (s2_cell) begin
                s3_attr <= mem.vram_data[15:8];
                s3_hit  <= s2_hit;
            end
        end
    end

    assign mem.glyph_ce   = s2_cell;
    assign mem.glyph_char = s2_cell ? mem.vram_data[7:0] : 8'h00;
    assign mem.glyph_row  = s2_gy;

    // Stage 4: shifter and colour lookup, outputs registered
    logic [GLYPH_W-1:0] shift_q, bits_now;
    logic [3:0]         fg_q, bg_q, fg_now, bg_now;

    always_comb begin
        bits_now = s3_cell ? mem.glyph_bits : shift_q;
        fg_now   = fg_q;
        bg_now   = bg_q;
        if (s3_cell) begin
            fg_now = s3_hit ? s3_attr[7:4] : s3_attr[3:0];
            bg_now = s3_hit ? s3_attr[3:0] : s3_attr[7:4];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q    <= '0;
            fg_q       <= '0;
            bg_q       <= '0;
            out_active <= 1'b0;
            out_h_sync <= 1'b0;
            out_v_sync <= 1'b0;
            out_rgb    <= '0;
        end else begin
            shift_q    <= {bits_now[GLYPH_W-2:0], 1'b0};
            fg_q       <= fg_now;
            bg_q       <= bg_now;
            out_active <= s3_active;
            out_h_sync <= s3_hs;
            out_v_sync <= s3_vs;
            out_rgb    <= s3_active ? palette(bits_now[GLYPH_W-1] ? fg_now : bg_now) : 24'h0;
        end
    end
endmodule

// File: tb/tb_hdmi_text_render.sv
// Scoreboard bench for hdmi_text_render: stimulus pushes expected pixels and memory reads,
// a monitor pops and compares them against the DUT.
module tb_hdmi_text_render;
    localparam int COLS = 100;
    localparam int ROWS = 30;
    localparam int GW   = 10;
    localparam int GH   = 20;
    localparam int BF   = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_active = 1'b0, in_h_sync = 1'b0, in_v_sync = 1'b0;
    logic       in_h_start = 1'b0, in_v_start = 1'b0;
    logic [4:0] top_row = '0;
    logic       cursor_en = 1'b0;
    logic [4:0] cursor_row = '0;
    logic [6:0] cursor_col = '0;
    logic       out_active, out_h_sync, out_v_sync;
    logic [23:0] out_rgb;

    always #5 clk = ~clk;

    hdmi_text_render_if #(.COLS(COLS), .ROWS(ROWS), .GLYPH_W(GW), .GLYPH_H(GH)) mem ();

    hdmi_text_render #(
        .COLS(COLS), .ROWS(ROWS), .GLYPH_W(GW), .GLYPH_H(GH), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .reset(reset),
        .in_active(in_active), .in_h_sync(in_h_sync), .in_v_sync(in_v_sync),
        .in_h_start(in_h_start), .in_v_start(in_v_start),
        .top_row(top_row), .cursor_en(cursor_en),
        .cursor_row(cursor_row), .cursor_col(cursor_col),
        .mem(mem),
        .out_active(out_active), .out_h_sync(out_h_sync), .out_v_sync(out_v_sync),
        .out_rgb(out_rgb)
    );

    typedef struct { int due; logic act; logic hs; logic vs; logic [23:0] rgb; } px_t;
    typedef struct { int due; logic [4:0] row; logic [6:0] col; } rd_t;
    typedef struct { int due; logic [7:0] ch; logic [4:0] gy; } gl_t;
    px_t pq[$];
    rd_t vq[$];
    gl_t gq[$];

    int  cyc = 0;
    int  nchk = 0, nerr = 0;
    bit  done = 1'b0;
    int  fidx = -1, ln = 0, ftop = 0;
    logic [15:0] vram [ROWS][COLS];
    logic [23:0] ehand [20];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pal(input logic [3:0] i);
        case (i)
            4'h0: return 24'h000000;  4'h1: return 24'h0000AA;
            4'h2: return 24'h00AA00;  4'h3: return 24'h00AAAA;
            4'h4: return 24'hAA0000;  4'h5: return 24'hAA00AA;
            4'h6: return 24'hAAAA00;  4'h7: return 24'hAAAAAA;
            4'h8: return 24'h555555;  4'h9: return 24'h5555FF;
            4'hA: return 24'h55FF55;  4'hB: return 24'h55FFFF;
            4'hC: return 24'hFF5555;  4'hD: return 24'hFF55FF;
            4'hE: return 24'hFFFF55;  default: return 24'hFFFFFF;
        endcase
    endfunction

    function automatic logic [9:0] glyph_fn(input logic [7:0] c, input logic [4:0] l);
        if (c == 8'h41 && l == 5'd0) return 10'b1000000001;
        return {c[4:0], l} ^ 10'h2B5;
    endfunction

    // Memory models: one-cycle read latency
    always @(posedge clk) begin
        if (mem.vram_ce) mem.vram_data <= vram[mem.vram_row][mem.vram_col];
        if (mem.glyph_ce) mem.glyph_bits <= glyph_fn(mem.glyph_char, mem.glyph_row);
    end

    task automatic step(input logic act, input logic hs, input logic vs, input logic hst,
                        input logic vst, input logic [23:0] rgb);
        in_active  = act;
        in_h_sync  = hs;
        in_v_sync  = vs;
        in_h_start = hst;
        in_v_start = vst;
        pq.push_back('{cyc + 4, act, hs, vs, act ? rgb : 24'h0});
        @(posedge clk);
        #1;
    endtask

    task automatic blank();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic new_line(input bit vst);
        step(1'b0, 1'b1, vst, 1'b0, 1'b0, 24'h0);
        blank();
        if (vst) begin
            fidx++;
            ln   = 0;
            ftop = int'(top_row);
        end else begin
            ln++;
        end
    endtask

    // Expected pixel from screen position: VRAM row scrolls by ftop, column saturates.
    task automatic pix(input int x, input bit vst);
        int r, c, gyv;
        logic [15:0] w;
        logic [9:0]  bits;
        logic [3:0]  fg, bg, t;
        logic        hit;
        r    = (ftop + ln / GH) % ROWS;
        gyv  = ln % GH;
        c    = (x / GW > COLS - 1) ? COLS - 1 : x / GW;
        w    = vram[r][c];
        bits = glyph_fn(w[7:0], 5'(gyv));
        fg   = w[11:8];
        bg   = w[15:12];
        hit  = cursor_en && ((fidx / BF) % 2 == 0) && r == int'(cursor_row)
               && c == int'(cursor_col);
        if (hit) begin
            t  = fg;
            fg = bg;
            bg = t;
        end
        if (x % GW == 0) begin
            vq.push_back('{cyc + 1, 5'(r), 7'(c)});
            gq.push_back('{cyc + 2, w[7:0], 5'(gyv)});
        end
        step(1'b1, 1'b0, 1'b0, x == 0, vst && x == 0, bits[GW-1-(x%GW)] ? pal(fg) : pal(bg));
    endtask

    task automatic line(input int npix, input bit vst);
        new_line(vst);
        for (int x = 0; x < npix; x++) pix(x, vst);
        blank();
    endtask

    // Directed line on VRAM row 0 with expected colours given literally
    task automatic hand_frame(input int n, input logic [23:0] exp [20]);
        new_line(1'b1);
        for (int x = 0; x < n; x++) begin
            if (x % GW == 0) begin
                vq.push_back('{cyc + 1, 5'd0, 7'(x / GW)});
                gq.push_back('{cyc + 2, 8'h41, 5'd0});
            end
            step(1'b1, 1'b0, 1'b0, x == 0, x == 0, exp[x]);
        end
        blank();
    endtask

    initial begin : monitor
        px_t p;
        rd_t v;
        gl_t g;
        forever begin
            @(negedge clk or posedge reset);
            if (reset) begin
                #1;
                nchk++;
                if ({out_active, out_h_sync, out_v_sync, out_rgb, mem.vram_ce, mem.glyph_ce,
                     mem.vram_row, mem.vram_col, mem.glyph_char, mem.glyph_row} !== 54'h0) begin
                    nerr++;
                    $display("FAIL reset_clear: got act=%b rgb=%h vce=%b gce=%b row=%0d col=%0d, want all 0",
                             out_active, out_rgb, mem.vram_ce, mem.glyph_ce, mem.vram_row, mem.vram_col);
                end
            end else if (done) begin
                nchk++;
                if (pq.size() + vq.size() + gq.size() != 0) begin
                    nerr++;
                    $display("FAIL drain: got %0d/%0d/%0d pending pixel/vram/glyph, want 0/0/0",
                             pq.size(), vq.size(), gq.size());
                end
                $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
                $finish;
            end else begin
                if (pq.size() > 0 && pq[0].due == cyc) begin
                    p = pq.pop_front();
                    nchk++;
                    if ({out_active, out_h_sync, out_v_sync, out_rgb} !== {p.act, p.hs, p.vs, p.rgb}) begin
                        nerr++;
                        $display("FAIL pixel cyc=%0d: got a/h/v=%b%b%b rgb=%h, want %b%b%b rgb=%h",
                                 cyc, out_active, out_h_sync, out_v_sync, out_rgb,
                                 p.act, p.hs, p.vs, p.rgb);
                    end
                end
                if (mem.vram_ce) begin
                    nchk++;
                    if (vq.size() == 0) begin
                        nerr++;
                        $display("FAIL vram_read cyc=%0d: got unexpected read, want none", cyc);
                    end else begin
                        v = vq.pop_front();
                        if (v.due != cyc || mem.vram_row !== v.row || mem.vram_col !== v.col) begin
                            nerr++;
                            $display("FAIL vram_read: got cyc=%0d (%0d,%0d), want cyc=%0d (%0d,%0d)",
                                     cyc, mem.vram_row, mem.vram_col, v.due, v.row, v.col);
                        end
                    end
                end else if (vq.size() > 0 && vq[0].due < cyc) begin
                    v = vq.pop_front();
                    nchk++;
                    nerr++;
                    $display("FAIL vram_read: got no read, want cyc=%0d (%0d,%0d)", v.due, v.row, v.col);
                end
                if (mem.glyph_ce) begin
                    nchk++;
                    if (gq.size() == 0) begin
                        nerr++;
                        $display("FAIL glyph_read cyc=%0d: got unexpected read, want none", cyc);
                    end else begin
                        g = gq.pop_front();
                        if (g.due != cyc || mem.glyph_char !== g.ch || mem.glyph_row !== g.gy) begin
                            nerr++;
                            $display("FAIL glyph_read: got cyc=%0d ch=%h gy=%0d, want cyc=%0d ch=%h gy=%0d",
                                     cyc, mem.glyph_char, mem.glyph_row, g.due, g.ch, g.gy);
                        end
                    end
                end else if (gq.size() > 0 && gq[0].due < cyc) begin
                    g = gq.pop_front();
                    nchk++;
                    nerr++;
                    $display("FAIL glyph_read: got no read, want cyc=%0d ch=%h gy=%0d", g.due, g.ch, g.gy);
                end
            end
        end
    end

    initial begin : stimulus
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                vram[r][c] = {4'(c + 1), 4'(r), 8'(r * 3 + c)};
        vram[0][0] = 16'h1F41;
        vram[0][1] = 16'h0741;
        // Cell 0: fg F on bg 1. Cell 1 under cursor: attr 07 swapped -> fg 0 on bg 7.
        for (int i = 0; i < 20; i++) begin
            if (i < 10) ehand[i] = (i % 10 == 0 || i % 10 == 9) ? 24'hFFFFFF : 24'h0000AA;
            else        ehand[i] = (i % 10 == 0 || i % 10 == 9) ? 24'h000000 : 24'hAAAAAA;
        end

        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        blank();

        hand_frame(10, ehand);
        cursor_en  = 1'b1;
        cursor_row = 5'd0;
        cursor_col = 7'd1;
        hand_frame(20, ehand);

        // Scroll wrap, with a mid-frame top_row change that must not apply until next frame
        cursor_en = 1'b0;
        top_row   = 5'd29;
        line(12, 1'b1);
        top_row = 5'd3;
        for (int l = 1; l < 21; l++) line(12, 1'b0);
        line(12, 1'b1);

        // Line longer than COLS cells: column saturates at COLS-1
        top_row = 5'd0;
        line(1012, 1'b1);

        repeat (40) step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0, 24'h0);

        cursor_en = 1'b1;
        while (fidx < 61) line(20, 1'b1);

        // Reset in the middle of a line, then a clean frame
        new_line(1'b1);
        for (int x = 0; x < 57; x++) pix(x, 1'b1);
        reset = 1'b1;
        pq.delete();
        vq.delete();
        gq.delete();
        in_active  = 1'b0;
        in_h_sync  = 1'b0;
        in_v_sync  = 1'b0;
        in_h_start = 1'b0;
        in_v_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        fidx = -1;
        ln   = 0;
        repeat (3) blank();
        line(25, 1'b1);
        line(25, 1'b0);

        repeat (4) blank();
        repeat (6) @(posedge clk);
        #1 done = 1'b1;
        #1000;
        $display("FAIL timeout: monitor did not reach the summary");
        $fatal(1);
    end
endmodule
